tqv_bus_initiator_fifo: RTL and testbench
=========================================

Name: tqv_bus_initiator_fifo

Overview:
- Bus initiator (master) for the TinyQV peripheral register interface: the opposite end of the address/data_in/data_write_n/data_read_n/data_out/data_ready port set that every user peripheral exposes.
- Accepts register commands from a local command port and drives them onto one peripheral, one at a time, with a mandatory idle gap between them.
- Read results go into a small response FIFO.
- Used to seed and drain peripherals (e.g. a PRNG) without the CPU: in hardware-only test harnesses and in autonomous streaming blocks.

Parameters:
- FIFO_DEPTH, 4, response FIFO entries (power of two, 2..16).
- TIMEOUT, 255, max cycles a strobe is held waiting for data_ready (1..255).

Ports:
- clk  in  1  project clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  6  peripheral register address
- cmd_size  in  2  00=8b, 01=16b, 10=32b; 11 treated as 10
- cmd_wdata  in  32  write data
- rsp_valid  out  1  FIFO not empty
- rsp_ready  in  1  pop when rsp_valid && rsp_ready
- rsp_data  out  32  head entry data
- rsp_err  out  1  head entry timed out
- wr_err  out  1  sticky: a write timed out
- clr_err  in  1  synchronous clear of wr_err
- address  out  6  to peripheral
- data_in  out  32  to peripheral
- data_write_n  out  2  to peripheral, 11 = idle
- data_read_n  out  2  to peripheral, 11 = idle
- data_out  in  32  from peripheral
- data_ready  in  1  from peripheral

Behaviour:
- Reset (async, asserted):
  - data_write_n = data_read_n = 11; address = 0; data_in = 0.
  - FIFO empty; rsp_valid = 0; wr_err = 0; state IDLE.
  - Reset asserted mid-transaction aborts it immediately; no response is produced.
- All peripheral-side outputs are registered.
- FSM IDLE -> REQ -> GAP -> IDLE.
- IDLE:
  - cmd_ready = 1 for writes.
  - For reads, cmd_ready = 1 only if (FIFO count + pending reads) < FIFO_DEPTH, so a slot is reserved before issue.
  - On accept, the next cycle enters REQ with address, data_in and the strobe driven.
  - The strobe is data_write_n = size for writes or data_read_n = size for reads; the other strobe stays 11.
  - Outside IDLE, cmd_ready = 0.
- REQ:
  - Strobe, address and data_in are held stable.
  - data_ready is sampled each cycle.
  - When it is high: for a read, data_out is pushed to the FIFO with err = 0 at that edge; then go to GAP.
  - A cycle counter starts at 1 in the first REQ cycle.
  - If the counter reaches TIMEOUT with data_ready still low:
    - Read: push data = 0, err = 1.
    - Write: set wr_err.
    - Then go to GAP.
  - data_ready high on the TIMEOUT cycle counts as success.
- GAP:
  - Exactly one cycle with both strobes = 11; address and data_in hold.
  - Guarantees peripherals that act once per strobe edge, e.g. the PRNG advancing on a read, see distinct requests.
  - Then IDLE.
- Timing with data_ready tied high: accept in cycle N, strobe in N+1, rsp_valid in N+2, next accept in N+3. Throughput is one transaction per 3 cycles.
- FIFO:
  - Push and pop in the same cycle leaves the count unchanged.
  - Pop when empty is ignored.
  - Overflow cannot occur because of slot reservation.
  - rsp_data/rsp_err show the head entry and are 0 when empty.
- clr_err is synchronous. If clr_err and a write timeout occur in the same cycle, wr_err is set (set wins).
- A write never pushes to the FIFO.

Test Plan:
- Responder with data_ready tied high returning data_out = 0xA5A5_0000 + read count. Issue 3 back-to-back 32-bit reads at addr 0 with rsp_ready = 1 → each strobe lasts exactly 1 cycle with an 11 gap between; rsp_data = 0xA5A50000, 0xA5A50001, 0xA5A50002; accepts at cycles 0, 3, 6.
- 32-bit write 0xDEADBEEF to addr 1, then 8-bit write 0x5A to addr 2 → data_write_n = 10 then 00, matching address/data_in; data_read_n stays 11; FIFO stays empty.
- rsp_ready = 0, issue 5 reads with FIFO_DEPTH = 4 → 4 accepted, cmd_ready stays 0 for the 5th; one pop → 5th accepted and its data appears after the previous 4.
- Responder delays data_ready by 7 cycles → strobe held 8 cycles, data captured on the ready cycle, err = 0.
- Responder never asserts ready, TIMEOUT = 255:
  - Read → strobe held 255 cycles, then entry data = 0, err = 1.
  - Write → wr_err = 1.
  - clr_err pulse → wr_err = 0.
- Assert rst_n low during REQ → strobes go 11 without waiting for a clock edge; FIFO empty, rsp_valid = 0; after release, the first accepted command completes normally.

Source files
------------

// File: rtl/tqv_bus_initiator_fifo.sv
// Bus initiator for the TinyQV peripheral register interface.
// Issues one register command at a time onto a peripheral.
// Each request is followed by a mandatory one-cycle idle gap.
// Read results, including read timeouts, are queued in a small response FIFO.
module tqv_bus_initiator_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [5:0]  cmd_addr,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        wr_err,
    input  logic        clr_err,
    output logic [5:0]  address,
    output logic [31:0] data_in,
    output logic [1:0]  data_write_n,
    output logic [1:0]  data_read_n,
    input  logic [31:0] data_out,
    input  logic        data_ready
);

    localparam int             AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]    DEPTH_C   = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]     TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_is_read;
    logic [7:0]    r_cycles;
    logic [5:0]    r_address;
    logic [31:0]   r_data_in;
    logic [1:0]    r_write_n;
    logic [1:0]    r_read_n;
    logic          r_wr_err;

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [32:0]   r_mem [FIFO_DEPTH];

    logic          w_accept;
    logic          w_done;
    logic          w_timeout;
    logic          w_push;
    logic          w_pop;
    logic [32:0]   w_push_entry;
    logic [32:0]   w_head;
    logic [1:0]    w_size;

    // Size 11 is an alias for a 32-bit access.
    assign w_size = (cmd_size == 2'b11) ? 2'b10 : cmd_size;

    // A read in flight always lands in the FIFO before the FSM returns to
    // IDLE, so in IDLE the occupancy alone is the reserved-slot count.
    assign cmd_ready = (r_state == ST_IDLE) && (cmd_write || (r_count < DEPTH_C));
    assign w_accept  = cmd_valid && cmd_ready;

    // data_ready on the final allowed cycle still counts as success.
    assign w_done       = (r_state == ST_REQ) && data_ready;
    assign w_timeout    = (r_state == ST_REQ) && !data_ready && (r_cycles == TIMEOUT_C);
    assign w_push       = r_is_read && (w_done || w_timeout);
    assign w_push_entry = w_done ? {1'b0, data_out} : {1'b1, 32'h0};
    assign w_pop        = (r_count != '0) && rsp_ready;

    assign w_head    = r_mem[r_rptr];
    assign rsp_valid = (r_count != '0);
    assign rsp_data  = rsp_valid ? w_head[31:0] : 32'h0;
    assign rsp_err   = rsp_valid ? w_head[32] : 1'b0;

    assign address      = r_address;
    assign data_in      = r_data_in;
    assign data_write_n = r_write_n;
    assign data_read_n  = r_read_n;
    assign wr_err       = r_wr_err;

    // Request sequencer: IDLE -> REQ (strobe held) -> GAP (strobes idle) -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_is_read <= 1'b0;
            r_cycles  <= 8'd0;
            r_address <= 6'd0;
            r_data_in <= 32'h0;
            r_write_n <= 2'b11;
            r_read_n  <= 2'b11;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_address <= cmd_addr;
                        r_data_in <= cmd_wdata;
                        r_is_read <= !cmd_write;
                        r_cycles  <= 8'd1;
                        if (cmd_write) begin
                            r_write_n <= w_size;
                        end else begin
                            r_read_n  <= w_size;
                        end
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_done || w_timeout) begin
                        r_write_n <= 2'b11;
                        r_read_n  <= 2'b11;
                        r_state   <= ST_GAP;
                    end else begin
                        r_cycles  <= r_cycles + 8'd1;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky write-timeout flag; a new timeout takes priority over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_err <= 1'b0;
        end else if (w_timeout && !r_is_read) begin
            r_wr_err <= 1'b1;
        end else if (clr_err) begin
            r_wr_err <= 1'b0;
        end
    end

    // Response FIFO pointers and occupancy; simultaneous push and pop cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Response storage; contents are only observed while occupancy covers them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_entry;
        end
    end

endmodule

// File: tb/tb_tqv_bus_initiator_fifo.sv
// Directed testbench for tqv_bus_initiator_fifo with a behavioural peripheral.
module tb_tqv_bus_initiator_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [5:0]  cmd_addr;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        wr_err;
    logic        clr_err;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    // Peripheral model: ready after tb_delay cycles of a held strobe.
    // Read data = A5A50000 + reads since rd_base + (cycles held << 8).
    int rd_count = 0;
    int rd_base  = 0;
    int hold_cnt = 0;
    int tb_delay = 0;
    bit ready_en = 1'b1;

    assign data_ready = ready_en && (hold_cnt >= tb_delay);
    assign data_out   = 32'hA5A5_0000 + 32'(rd_count - rd_base) + (32'(hold_cnt) << 8);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (data_read_n != 2'b11 && data_ready) rd_count <= rd_count + 1;
        if (data_read_n != 2'b11 || data_write_n != 2'b11) hold_cnt <= hold_cnt + 1;
        else hold_cnt <= 0;
    end

    tqv_bus_initiator_fifo #(.FIFO_DEPTH(4), .TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .wr_err(wr_err), .clr_err(clr_err),
        .address(address), .data_in(data_in), .data_write_n(data_write_n),
        .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready)
    );

    typedef struct {
        logic        vld;
        logic        wr;
        logic [5:0]  addr;
        logic [1:0]  sz;
        logic [31:0] wdata;
        logic        rrdy;
        logic        e_crdy;
        logic [1:0]  e_wn;
        logic [1:0]  e_rn;
        logic [5:0]  e_addr;
        logic [31:0] e_din;
        logic        e_rv;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end else begin
            $display("ok   %s: %0h", name, got);
        end
    endtask

    // Present a command until accepted; returns in the first REQ cycle (posedge+1).
    task automatic issue(input logic wr, input logic [5:0] a, input logic [1:0] sz,
                         input logic [31:0] wd, input int budget, output bit ok);
        ok = 1'b0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_size = sz; cmd_wdata = wd;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
    endtask

    // Count negedges on which a strobe is active; stops at the first idle one.
    task automatic strobe_len(input int budget, output int n);
        bit stop = 1'b0;
        n = 0;
        for (int k = 0; k < budget && !stop; k++) begin
            @(negedge clk);
            if (data_read_n != 2'b11 || data_write_n != 2'b11) n++;
            else stop = 1'b1;
        end
    endtask

    // Wait for a response, compare the head, then pop it.
    task automatic pop_check(input string name, input logic [31:0] ed, input logic ee);
        bit seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: no response within budget, required %0h err %b", name, ed, ee);
        end else if ({rsp_err, rsp_data} !== {ee, ed}) begin
            n_fail++;
            $display("FAIL %s: got %0h err %b required %0h err %b", name, rsp_data, rsp_err, ed, ee);
        end else begin
            $display("ok   %s: %0h err %b", name, rsp_data, rsp_err);
        end
        if (seen) begin
            @(posedge clk); #1; rsp_ready = 1'b1;
            @(posedge clk); #1; rsp_ready = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int n;
        int seen_rdy;

        //             vld wr addr sz  wdata         rrdy crdy wn     rn     addr  din           rv  rdata
        vecs[0]  = '{1'b1,1'b0,6'd0,2'd2,32'h0,        1'b1,1'b1,2'b11,2'b11,6'd0,32'h0,        1'b0,32'h0};
        vecs[1]  = '{1'b1,1'b0,6'd0,2'd2,32'h0,        1'b1,1'b0,2'b11,2'b10,6'd0,32'h0,        1'b0,32'h0};
        vecs[2]  = '{1'b1,1'b0,6'd0,2'd2,32'h0,        1'b1,1'b0,2'b11,2'b11,6'd0,32'h0,        1'b1,32'hA5A50000};
        vecs[3]  = '{1'b1,1'b0,6'd0,2'd3,32'h0,        1'b1,1'b1,2'b11,2'b11,6'd0,32'h0,        1'b0,32'h0};
        vecs[4]  = '{1'b1,1'b0,6'd0,2'd3,32'h0,        1'b1,1'b0,2'b11,2'b10,6'd0,32'h0,        1'b0,32'h0};
        vecs[5]  = '{1'b1,1'b0,6'd0,2'd2,32'h0,        1'b1,1'b0,2'b11,2'b11,6'd0,32'h0,        1'b1,32'hA5A50001};
        vecs[6]  = '{1'b1,1'b0,6'd0,2'd2,32'h0,        1'b1,1'b1,2'b11,2'b11,6'd0,32'h0,        1'b0,32'h0};
        vecs[7]  = '{1'b1,1'b0,6'd0,2'd2,32'h0,        1'b1,1'b0,2'b11,2'b10,6'd0,32'h0,        1'b0,32'h0};
        vecs[8]  = '{1'b1,1'b1,6'd1,2'd2,32'hDEADBEEF, 1'b1,1'b0,2'b11,2'b11,6'd0,32'h0,        1'b1,32'hA5A50002};
        vecs[9]  = '{1'b1,1'b1,6'd1,2'd2,32'hDEADBEEF, 1'b1,1'b1,2'b11,2'b11,6'd0,32'h0,        1'b0,32'h0};
        vecs[10] = '{1'b1,1'b1,6'd2,2'd0,32'h5A,       1'b1,1'b0,2'b10,2'b11,6'd1,32'hDEADBEEF, 1'b0,32'h0};
        vecs[11] = '{1'b1,1'b1,6'd2,2'd0,32'h5A,       1'b1,1'b0,2'b11,2'b11,6'd1,32'hDEADBEEF, 1'b0,32'h0};
        vecs[12] = '{1'b1,1'b1,6'd2,2'd0,32'h5A,       1'b1,1'b1,2'b11,2'b11,6'd1,32'hDEADBEEF, 1'b0,32'h0};
        vecs[13] = '{1'b0,1'b0,6'd0,2'd0,32'h0,        1'b1,1'b0,2'b00,2'b11,6'd2,32'h5A,       1'b0,32'h0};
        vecs[14] = '{1'b0,1'b0,6'd0,2'd0,32'h0,        1'b1,1'b0,2'b11,2'b11,6'd2,32'h5A,       1'b0,32'h0};
        vecs[15] = '{1'b0,1'b0,6'd0,2'd0,32'h0,        1'b1,1'b1,2'b11,2'b11,6'd2,32'h5A,       1'b0,32'h0};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 6'd0; cmd_size = 2'd0;
        cmd_wdata = 32'h0; rsp_ready = 1'b0; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {data_write_n, data_read_n, address, data_in, rsp_valid, wr_err, rsp_data},
              {2'b11, 2'b11, 6'd0, 32'h0, 1'b0, 1'b0, 32'h0});
        @(posedge clk); #1; rst_n = 1'b1;
        rd_base = rd_count;

        // Back-to-back reads then two writes, cycle by cycle.
        for (int i = 0; i < 16; i++) begin
            cmd_valid = vecs[i].vld; cmd_write = vecs[i].wr; cmd_addr = vecs[i].addr;
            cmd_size = vecs[i].sz; cmd_wdata = vecs[i].wdata; rsp_ready = vecs[i].rrdy;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {cmd_ready, data_write_n, data_read_n, address, data_in, rsp_valid, rsp_data},
                  {vecs[i].e_crdy, vecs[i].e_wn, vecs[i].e_rn, vecs[i].e_addr, vecs[i].e_din,
                   vecs[i].e_rv, vecs[i].e_rdata});
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0;

        // Slot reservation: four reads fill the FIFO, the fifth waits for a pop.
        rd_base = rd_count;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 6'd3, 2'd2, 32'h0, 10, ok);
            check($sformatf("fill_accept%0d", i), 128'(ok), 128'(1));
        end
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'd3; cmd_size = 2'd2;
        seen_rdy = 0;
        repeat (10) begin
            @(negedge clk);
            if (cmd_ready) seen_rdy++;
            @(posedge clk); #1;
        end
        check("fifth_blocked", 128'(seen_rdy), 128'(0));
        pop_check("fill_pop0", 32'hA5A50000, 1'b0);
        issue(1'b0, 6'd3, 2'd2, 32'h0, 5, ok);
        check("fifth_accept", 128'(ok), 128'(1));
        pop_check("fill_pop1", 32'hA5A50001, 1'b0);
        pop_check("fill_pop2", 32'hA5A50002, 1'b0);
        pop_check("fill_pop3", 32'hA5A50003, 1'b0);
        pop_check("fill_pop4", 32'hA5A50004, 1'b0);
        @(negedge clk);
        check("drained", {rsp_valid, rsp_err, rsp_data}, {1'b0, 1'b0, 32'h0});
        @(posedge clk); #1;

        // Delayed ready: seven low cycles, data captured on the eighth.
        tb_delay = 7; rd_base = rd_count;
        issue(1'b0, 6'd4, 2'd2, 32'h0, 10, ok);
        strobe_len(400, n);
        check("delay_strobe_len", 128'(n), 128'(8));
        pop_check("delay_data", 32'hA5A50700, 1'b0);

        // Peripheral never ready: read and write timeouts.
        ready_en = 1'b0;
        issue(1'b0, 6'd5, 2'd2, 32'h0, 10, ok);
        strobe_len(400, n);
        check("rd_timeout_len", 128'(n), 128'(255));
        pop_check("rd_timeout_entry", 32'h0, 1'b1);
        @(negedge clk);
        check("wr_err_before", 128'(wr_err), 128'(0));
        @(posedge clk); #1;
        issue(1'b1, 6'd7, 2'd1, 32'h1234, 10, ok);
        strobe_len(400, n);
        check("wr_timeout_len", 128'(n), 128'(255));
        check("wr_timeout_flag", {wr_err, rsp_valid}, {1'b1, 1'b0});
        @(posedge clk); #1; clr_err = 1'b1;
        @(posedge clk); #1; clr_err = 1'b0;
        @(negedge clk);
        check("wr_err_cleared", 128'(wr_err), 128'(0));
        @(posedge clk); #1;
        clr_err = 1'b1;
        issue(1'b1, 6'd7, 2'd2, 32'h5678, 10, ok);
        strobe_len(400, n);
        check("set_beats_clear", 128'(wr_err), 128'(1));
        @(posedge clk); #1; clr_err = 1'b0;
        @(negedge clk);
        check("clear_after_gap", 128'(wr_err), 128'(0));
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a request.
        ready_en = 1'b1; tb_delay = 0;
        issue(1'b0, 6'd9, 2'd2, 32'h0, 10, ok);
        repeat (3) @(posedge clk);
        #1;
        tb_delay = 7;
        issue(1'b0, 6'd9, 2'd2, 32'h0, 10, ok);
        @(negedge clk);
        check("pre_reset", {rsp_valid, data_read_n}, {1'b1, 2'b10});
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", {data_write_n, data_read_n, address, data_in, rsp_valid},
              {2'b11, 2'b11, 6'd0, 32'h0, 1'b0});
        @(posedge clk); #1;
        rst_n = 1'b1; tb_delay = 0; rd_base = rd_count;
        issue(1'b0, 6'd4, 2'd2, 32'h0, 10, ok);
        check("post_reset_accept", 128'(ok), 128'(1));
        pop_check("post_reset_data", 32'hA5A50000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
